// File: rtl/keyboard_playback_ctrl_if.sv
// Control/status bundle between the keyboard decoder, the audio sample clock
// and the playback controller that owns the flash read address.
interface keyboard_playback_ctrl_if #(
  parameter int ADDR_W    = 23,
  parameter int SPEED_MAX = 3
);
  localparam int SPEED_W = $clog2(SPEED_MAX + 1);

  logic [7:0]         pressedkey;
  logic               sample_tick;
  logic [ADDR_W-1:0]  address;
  logic               addr_strobe;
  logic               direction;
  logic               pause;
  logic               restart;
  logic               done;
  logic [SPEED_W-1:0] speed;
  logic               loop_en;

  modport master (
    output pressedkey, sample_tick,
    input  address, addr_strobe, direction, pause, restart, done, speed, loop_en
  );

  modport slave (
    input  pressedkey, sample_tick,
    output address, addr_strobe, direction, pause, restart, done, speed, loop_en
  );
endinterface

// File: rtl/keyboard_playback_ctrl.sv
// Keyboard-driven playback FSM: turns ASCII key events into play/pause/direction/
// restart control and steps the flash read address once per audio sample tick.
module keyboard_playback_ctrl #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF,
  parameter int                SPEED_MAX  = 3,
  parameter logic [7:0]        KEY_E      = 8'h45,
  parameter logic [7:0]        KEY_D      = 8'h44,
  parameter logic [7:0]        KEY_B      = 8'h42,
  parameter logic [7:0]        KEY_F      = 8'h46,
  parameter logic [7:0]        KEY_R      = 8'h52,
  parameter logic [7:0]        KEY_U      = 8'h55,
  parameter logic [7:0]        KEY_S      = 8'h53,
  parameter logic [7:0]        KEY_L      = 8'h4C
) (
  input logic clock,
  input logic reset,
  keyboard_playback_ctrl_if.slave bus
);
  localparam int SPEED_W = $clog2(SPEED_MAX + 1);

  typedef logic [ADDR_W:0]    ext_t;
  typedef logic [SPEED_W-1:0] spd_t;
  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, RESTART, DONE} state_t;

  function automatic spd_t spd_up(input spd_t s);
    return (s == spd_t'(SPEED_MAX)) ? s : s + spd_t'(1);
  endfunction

  function automatic spd_t spd_dn(input spd_t s);
    return (s == '0) ? s : s - spd_t'(1);
  endfunction

  state_t            state, state_n;
  logic [7:0]        key_p1;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              dir_q, dir_n;
  spd_t              spd_q, spd_n;
  logic              loop_q, loop_n;
  logic              strobe_q, strobe_n;
  logic              pause_q, restart_q, done_q;
  logic              adv;

  // A key event is a level change onto one of the recognised codes.
  logic key_chg;
  logic ev_e, ev_d, ev_b, ev_f, ev_r, ev_u, ev_s, ev_l;
  assign key_chg = (bus.pressedkey != key_p1);
  assign ev_e = key_chg && (bus.pressedkey == KEY_E);
  assign ev_d = key_chg && (bus.pressedkey == KEY_D);
  assign ev_b = key_chg && (bus.pressedkey == KEY_B);
  assign ev_f = key_chg && (bus.pressedkey == KEY_F);
  assign ev_r = key_chg && (bus.pressedkey == KEY_R);
  assign ev_u = key_chg && (bus.pressedkey == KEY_U);
  assign ev_s = key_chg && (bus.pressedkey == KEY_S);
  assign ev_l = key_chg && (bus.pressedkey == KEY_L);

  // One extra bit so boundary tests cannot overflow.
  ext_t step, fwd_sum, bwd_lim;
  assign step    = ext_t'(spd_q) + ext_t'(1);
  assign fwd_sum = ext_t'(addr_q) + step;
  assign bwd_lim = ext_t'(START_ADDR) + step;

  always_comb begin
    state_n  = state;
    dir_n    = dir_q;
    spd_n    = spd_q;
    loop_n   = loop_q;
    addr_n   = addr_q;
    strobe_n = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE, PAUSE: begin
        if (ev_e)      state_n = PLAY;
        else if (ev_b) begin state_n = PLAY; dir_n = 1'b0; end
        else if (ev_f) begin state_n = PLAY; dir_n = 1'b1; end
        else if (ev_r) state_n = RESTART;
      end
      PLAY: begin
        if (ev_d)      state_n = PAUSE;
        else if (ev_r) state_n = RESTART;
        else if (ev_b) dir_n = 1'b0;
        else if (ev_f) dir_n = 1'b1;
        else           adv = bus.sample_tick;
      end
      RESTART: begin
        addr_n   = dir_q ? START_ADDR : END_ADDR;
        strobe_n = 1'b1;
        state_n  = PLAY;
      end
      DONE: begin
        if (ev_r || ev_e) state_n = RESTART;
        else if (ev_b)    begin state_n = PLAY; dir_n = 1'b0; end
        else if (ev_f)    begin state_n = PLAY; dir_n = 1'b1; end
      end
      default: state_n = IDLE;
    endcase

    if (state != RESTART) begin
      if (ev_u) spd_n = spd_up(spd_q);
      if (ev_s) spd_n = spd_dn(spd_q);
      if (ev_l) loop_n = ~loop_q;
    end

    // Advance uses the speed held before any same-cycle U/S event.
    if (adv) begin
      strobe_n = 1'b1;
      if (dir_q) begin
        if (fwd_sum > ext_t'(END_ADDR)) begin
          if (loop_q) addr_n = START_ADDR;
          else begin addr_n = END_ADDR; state_n = DONE; end
        end else begin
          addr_n = fwd_sum[ADDR_W-1:0];
        end
      end else begin
        if (ext_t'(addr_q) < bwd_lim) begin
          if (loop_q) addr_n = END_ADDR;
          else begin addr_n = START_ADDR; state_n = DONE; end
        end else begin
          addr_n = addr_q - step[ADDR_W-1:0];
        end
      end
    end
  end

  // Stage p1: every output is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      key_p1    <= 8'h00;
      addr_q    <= START_ADDR;
      dir_q     <= 1'b1;
      spd_q     <= '0;
      loop_q    <= 1'b1;
      strobe_q  <= 1'b0;
      pause_q   <= 1'b1;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      key_p1    <= bus.pressedkey;
      addr_q    <= addr_n;
      dir_q     <= dir_n;
      spd_q     <= spd_n;
      loop_q    <= loop_n;
      strobe_q  <= strobe_n;
      pause_q   <= (state_n != PLAY);
      restart_q <= (state_n == RESTART);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.address     = addr_q;
  assign bus.addr_strobe = strobe_q;
  assign bus.direction   = dir_q;
  assign bus.pause       = pause_q;
  assign bus.restart     = restart_q;
  assign bus.done        = done_q;
  assign bus.speed       = spd_q;
  assign bus.loop_en     = loop_q;
endmodule

// File: tb/tb_keyboard_playback_ctrl.sv
// Directed bench for keyboard_playback_ctrl with a short sample window
// (START_ADDR=0, END_ADDR=40) so the boundaries are reachable in a few ticks.
module tb_keyboard_playback_ctrl;
  localparam logic [7:0] K_E = 8'h45, K_D = 8'h44, K_B = 8'h42, K_F = 8'h46;
  localparam logic [7:0] K_R = 8'h52, K_U = 8'h55, K_S = 8'h53, K_L = 8'h4C;

  logic clock = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clock = ~clock;

  keyboard_playback_ctrl_if #(.ADDR_W(23), .SPEED_MAX(3)) bus ();

  keyboard_playback_ctrl #(
    .ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd40), .SPEED_MAX(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    bus.pressedkey = k;
    cyc();
    bus.pressedkey = 8'h00;
    cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_addr"},    32'(bus.address),     32'd0);
    check_val({tag, "_dir"},     32'(bus.direction),   32'd1);
    check_val({tag, "_speed"},   32'(bus.speed),       32'd0);
    check_val({tag, "_loop"},    32'(bus.loop_en),     32'd1);
    check_val({tag, "_pause"},   32'(bus.pause),       32'd1);
    check_val({tag, "_restart"}, 32'(bus.restart),     32'd0);
    check_val({tag, "_done"},    32'(bus.done),        32'd0);
    check_val({tag, "_strobe"},  32'(bus.addr_strobe), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_a;
    reset = 1'b1;
    bus.pressedkey  = 8'h00;
    bus.sample_tick = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check_reset_vals("rst");

    // Play, then hold E while ticking: a single event, ten advances.
    bus.pressedkey = K_E;
    cyc();
    check_val("play_pause", 32'(bus.pause), 32'd0);
    check_val("play_addr0", 32'(bus.address), 32'd0);
    bus.sample_tick = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_val("tick_addr", 32'(bus.address), 32'(i));
      check_val("tick_strobe", 32'(bus.addr_strobe), 32'd1);
    end
    check_val("held_e_pause", 32'(bus.pause), 32'd0);

    // Pause freezes the address; ticks are dropped.
    bus.sample_tick = 1'b0;
    bus.pressedkey  = K_D;
    cyc();
    check_val("pause_hi", 32'(bus.pause), 32'd1);
    check_val("pause_addr", 32'(bus.address), 32'd10);
    bus.sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("pause_nostrobe", 32'(bus.addr_strobe), 32'd0);
      check_val("pause_hold", 32'(bus.address), 32'd10);
    end
    bus.sample_tick = 1'b0;
    bus.pressedkey  = 8'h00;
    cyc();
    press(K_E);
    check_val("resume_pause", 32'(bus.pause), 32'd0);

    // Speed saturation up and down.
    repeat (5) press(K_U);
    check_val("speed_sat_hi", 32'(bus.speed), 32'd3);
    bus.sample_tick = 1'b1;
    cyc();
    check_val("step4_addr", 32'(bus.address), 32'd14);
    check_val("step4_strobe", 32'(bus.addr_strobe), 32'd1);
    bus.sample_tick = 1'b0;
    cyc();
    check_val("idle_strobe", 32'(bus.addr_strobe), 32'd0);
    check_val("idle_addr", 32'(bus.address), 32'd14);
    repeat (4) press(K_S);
    check_val("speed_sat_lo", 32'(bus.speed), 32'd0);

    // Tick coinciding with U advances at the old speed.
    bus.pressedkey  = K_U;
    bus.sample_tick = 1'b1;
    cyc();
    check_val("u_tick_addr", 32'(bus.address), 32'd15);
    check_val("u_tick_speed", 32'(bus.speed), 32'd1);
    bus.pressedkey  = 8'h00;
    bus.sample_tick = 1'b0;
    cyc();
    repeat (2) press(K_U);
    check_val("speed3", 32'(bus.speed), 32'd3);

    // Forward wrap with loop enabled.
    bus.sample_tick = 1'b1;
    exp_a = 32'd15;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp_a = exp_a + 32'd4;
      check_val("fwd_addr", 32'(bus.address), exp_a);
    end
    cyc();
    check_val("wrap_addr", 32'(bus.address), 32'd0);
    check_val("wrap_strobe", 32'(bus.addr_strobe), 32'd1);
    check_val("wrap_pause", 32'(bus.pause), 32'd0);
    bus.sample_tick = 1'b0;
    cyc();

    // Loop off: clamp at END_ADDR and enter DONE.
    press(K_L);
    check_val("loop_off", 32'(bus.loop_en), 32'd0);
    bus.sample_tick = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check_val("run_addr", 32'(bus.address), 32'(4 * k));
    end
    cyc();
    check_val("clamp_addr", 32'(bus.address), 32'd40);
    check_val("clamp_done", 32'(bus.done), 32'd1);
    check_val("clamp_pause", 32'(bus.pause), 32'd1);
    check_val("clamp_strobe", 32'(bus.addr_strobe), 32'd1);
    cyc();
    check_val("done_nostrobe", 32'(bus.addr_strobe), 32'd0);
    check_val("done_addr", 32'(bus.address), 32'd40);
    check_val("done_hold", 32'(bus.done), 32'd1);
    bus.sample_tick = 1'b0;

    // B from DONE resumes backward from the boundary.
    bus.pressedkey = K_B;
    cyc();
    check_val("b_dir", 32'(bus.direction), 32'd0);
    check_val("b_done", 32'(bus.done), 32'd0);
    check_val("b_pause", 32'(bus.pause), 32'd0);
    check_val("b_addr", 32'(bus.address), 32'd40);
    bus.pressedkey  = 8'h00;
    bus.sample_tick = 1'b1;
    cyc();
    check_val("bwd_addr", 32'(bus.address), 32'd36);
    bus.sample_tick = 1'b0;

    // Restart while backward loads END_ADDR.
    bus.pressedkey = K_R;
    cyc();
    check_val("rs_restart", 32'(bus.restart), 32'd1);
    check_val("rs_pause", 32'(bus.pause), 32'd1);
    check_val("rs_addr", 32'(bus.address), 32'd36);
    bus.pressedkey = 8'h00;
    cyc();
    check_val("rs_restart_lo", 32'(bus.restart), 32'd0);
    check_val("rs_load", 32'(bus.address), 32'd40);
    check_val("rs_strobe", 32'(bus.addr_strobe), 32'd1);
    check_val("rs_play", 32'(bus.pause), 32'd0);
    cyc();
    check_val("rs_strobe_lo", 32'(bus.addr_strobe), 32'd0);

    // Reset mid-playback at speed 2 backward, with a tick and key in the same cycle.
    press(K_S);
    check_val("pre_rst_speed", 32'(bus.speed), 32'd2);
    bus.sample_tick = 1'b1;
    cyc();
    check_val("pre_rst_addr", 32'(bus.address), 32'd37);
    check_val("pre_rst_dir", 32'(bus.direction), 32'd0);
    reset = 1'b1;
    bus.pressedkey = K_F;
    cyc();
    check_reset_vals("midrst");
    reset = 1'b0;
    bus.pressedkey  = 8'h00;
    bus.sample_tick = 1'b0;
    cyc();
    check_val("post_rst_pause", 32'(bus.pause), 32'd1);

    // D is meaningless in IDLE; B from IDLE then wraps backward on the first tick.
    bus.pressedkey = K_D;
    cyc();
    check_val("idle_d_pause", 32'(bus.pause), 32'd1);
    bus.pressedkey = K_B;
    cyc();
    check_val("idle_b_dir", 32'(bus.direction), 32'd0);
    check_val("idle_b_pause", 32'(bus.pause), 32'd0);
    check_val("idle_b_addr", 32'(bus.address), 32'd0);
    bus.pressedkey  = 8'h00;
    bus.sample_tick = 1'b1;
    cyc();
    check_val("bwd_wrap_addr", 32'(bus.address), 32'd40);
    check_val("bwd_wrap_strobe", 32'(bus.addr_strobe), 32'd1);
    bus.sample_tick = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
